// File: rtl/proc_pipe.sv
// rtl/proc_pipe.sv - four-stage F/D/X/W pipeline with forwarding, redirect flush and exception vector
module proc_pipe #(
    parameter int ARCH_BITS = 32,
    parameter int NUM_REGS  = 32,
    parameter logic [ARCH_BITS-1:0] PC_RST    = 32'h0000_1000,
    parameter logic [ARCH_BITS-1:0] PC_EXCEPT = 32'h0000_2000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ARCH_BITS-1:0] imem_addr,
    input  logic [31:0]          imem_data,
    input  logic                 imem_valid,
    output logic                 wb_valid,
    output logic [4:0]           wb_dst,
    output logic [ARCH_BITS-1:0] wb_data,
    output logic                 exc,
    output logic                 redirect
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_MUL  = 7'h02;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_MOVI = 7'h15;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;
    localparam logic [6:0] OP_NOP  = 7'h7f;
    localparam logic [31:0] NOP_WORD = {OP_NOP, 25'd0};

    logic [ARCH_BITS-1:0] regs [NUM_REGS];
    logic [ARCH_BITS-1:0] pc;

    logic [31:0]          d_instr;
    logic [ARCH_BITS-1:0] d_pc;

    logic [6:0]           x_op;
    logic [4:0]           x_dst;
    logic [19:0]          x_lo;
    logic [ARCH_BITS-1:0] x_a;
    logic [ARCH_BITS-1:0] x_b;
    logic [ARCH_BITS-1:0] x_pc;

    logic                 w_valid;
    logic [4:0]           w_dst;
    logic [ARCH_BITS-1:0] w_data;

    logic [6:0]           d_op;
    logic [4:0]           d_dst;
    logic [4:0]           d_s1;
    logic [4:0]           d_s2;
    logic [ARCH_BITS-1:0] d_a;
    logic [ARCH_BITS-1:0] d_b;

    logic [ARCH_BITS-1:0] x_result;
    logic [ARCH_BITS-1:0] x_imm;
    logic [ARCH_BITS-1:0] x_off;
    logic [ARCH_BITS-1:0] x_target;
    logic                 x_is_alu;
    logic                 x_wen;
    logic                 x_illegal;
    logic                 x_taken;

    // X result beats W result beats the register file; R0 is always zero.
    function automatic logic [ARCH_BITS-1:0] fwd(
        input logic [4:0]           src,
        input logic [ARCH_BITS-1:0] rf,
        input logic                 xw,
        input logic [4:0]           xd,
        input logic [ARCH_BITS-1:0] xr,
        input logic                 wv,
        input logic [4:0]           wd,
        input logic [ARCH_BITS-1:0] wr
    );
        if (src == 5'd0)
            return '0;
        else if (xw && xd == src)
            return xr;
        else if (wv && wd == src)
            return wr;
        else
            return rf;
    endfunction

    assign d_op  = d_instr[31:25];
    assign d_dst = d_instr[24:20];
    assign d_s1  = d_instr[19:15];
    assign d_s2  = d_instr[14:10];

    always_comb begin
        d_a = fwd(d_s1, regs[d_s1[RW-1:0]], x_wen, x_dst, x_result, w_valid, w_dst, w_data);
        d_b = fwd(d_s2, regs[d_s2[RW-1:0]], x_wen, x_dst, x_result, w_valid, w_dst, w_data);
    end

    always_comb begin
        x_imm     = {{(ARCH_BITS-20){1'b0}}, x_lo};
        x_off     = {{(ARCH_BITS-15){x_dst[4]}}, x_dst, x_lo[9:0]};
        x_result  = '0;
        x_is_alu  = 1'b1;
        x_illegal = 1'b0;
        x_taken   = 1'b0;
        case (x_op)
            OP_ADD:  x_result = x_a + x_b;
            OP_SUB:  x_result = x_a - x_b;
            OP_MUL:  x_result = x_a * x_b;
            OP_MOV:  x_result = x_a;
            OP_MOVI: x_result = x_imm;
            OP_BEQ: begin
                x_is_alu = 1'b0;
                x_taken  = (x_a == x_b);
            end
            OP_JUMP: begin
                x_is_alu = 1'b0;
                x_taken  = 1'b1;
            end
            OP_NOP:  x_is_alu = 1'b0;
            default: begin
                x_is_alu  = 1'b0;
                x_illegal = 1'b1;
            end
        endcase
        x_wen    = x_is_alu && (x_dst != 5'd0);
        x_target = ((x_op == OP_JUMP) ? x_a : x_pc) + x_off;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= PC_RST;
            d_instr <= NOP_WORD;
            d_pc    <= '0;
            x_op    <= OP_NOP;
            x_dst   <= '0;
            x_lo    <= '0;
            x_a     <= '0;
            x_b     <= '0;
            x_pc    <= '0;
            w_valid <= 1'b0;
            w_dst   <= '0;
            w_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            w_valid <= x_wen;
            w_dst   <= x_dst;
            w_data  <= x_result;
            if (w_valid)
                regs[w_dst[RW-1:0]] <= w_data;

            x_dst <= d_dst;
            x_lo  <= d_instr[19:0];
            x_a   <= d_a;
            x_b   <= d_b;
            x_pc  <= d_pc;

            // A control transfer from X squashes both younger slots, including this cycle's fetch.
            if (x_taken || x_illegal) begin
                pc      <= x_illegal ? PC_EXCEPT : x_target;
                d_instr <= NOP_WORD;
                x_op    <= OP_NOP;
            end else begin
                x_op <= d_op;
                if (imem_valid) begin
                    d_instr <= imem_data;
                    d_pc    <= pc;
                    pc      <= pc + ARCH_BITS'(4);
                end else begin
                    d_instr <= NOP_WORD;
                end
            end
        end
    end

    assign imem_req  = ~rst;
    assign imem_addr = pc;
    assign wb_valid  = w_valid;
    assign wb_dst    = w_dst;
    assign wb_data   = w_data;
    assign exc       = x_illegal;
    assign redirect  = x_taken;

endmodule

// File: tb/tb_proc_pipe.sv
// tb/tb_proc_pipe.sv - directed scoreboard bench for proc_pipe
module tb_proc_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic        imem_valid = 1'b0;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        exc;
    logic        redirect;

    always #5 clk = ~clk;

    proc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .imem_valid(imem_valid),
        .wb_valid  (wb_valid),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data),
        .exc       (exc),
        .redirect  (redirect)
    );

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } commit_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] prog [logic [31:0]];
    commit_t     exp_q[$];
    int          commit_cyc[$];

    localparam logic [31:0] NOP_WORD = {7'h7f, 25'd0};

    function automatic logic [31:0] rr(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 10'd0};
    endfunction

    function automatic logic [31:0] movi(input logic [4:0] d, input logic [19:0] imm);
        return {7'h15, d, imm};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] s1, input logic [4:0] s2, input logic [14:0] off);
        return {7'h30, off[14:10], s1, s2, off[9:0]};
    endfunction

    function automatic logic [31:0] jmp(input logic [4:0] s1, input logic [14:0] off);
        return {7'h31, off[14:10], s1, 5'd0, off[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_commit(input logic [4:0] d, input logic [31:0] v);
        commit_t e;
        e.dst  = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v);
        commit_t e;
        imem_valid = v;
        imem_data  = prog.exists(imem_addr) ? prog[imem_addr] : NOP_WORD;
        @(posedge clk);
        #1;
        cyc++;
        if (wb_valid === 1'b1) begin
            commit_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("extra_commit_valid", {31'd0, wb_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("commit_dst", {27'd0, wb_dst}, {27'd0, e.dst});
                check("commit_data", wb_data, e.data);
            end
        end
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 32'd0);
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h1000);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_exc", {31'd0, exc}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        rst = 1'b0;
        #1;
        check("req_after_rst", {31'd0, imem_req}, 32'd1);
        exp_q.delete();
        commit_cyc.delete();
        prog.delete();
        cyc = 0;
    endtask

    task automatic wait_sig(input logic use_exc, input string tag);
        int n = 0;
        while (((use_exc ? exc : redirect) !== 1'b1) && n < 20) begin
            step(1'b1);
            n++;
        end
        check(tag, {31'd0, (use_exc ? exc : redirect)}, 32'd1);
    endtask

    initial begin
        do_reset();

        // back-to-back ALU ops, forwarding from W, X and the register file
        prog[32'h1000] = movi(5'd1, 20'd5);
        prog[32'h1004] = movi(5'd2, 20'd7);
        prog[32'h1008] = rr(7'h00, 5'd3, 5'd1, 5'd2);
        prog[32'h100C] = rr(7'h01, 5'd4, 5'd1, 5'd2);
        prog[32'h1010] = rr(7'h02, 5'd5, 5'd3, 5'd3);
        prog[32'h1014] = rr(7'h14, 5'd6, 5'd5, 5'd0);
        expect_commit(5'd1, 32'd5);
        expect_commit(5'd2, 32'd7);
        expect_commit(5'd3, 32'd12);
        expect_commit(5'd4, 32'hFFFF_FFFE);
        expect_commit(5'd5, 32'd144);
        expect_commit(5'd6, 32'd144);
        repeat (10) step(1'b1);
        check("A_commit_count", commit_cyc.size(), 32'd6);
        if (commit_cyc.size() == 6) begin
            check("A_first_latency", commit_cyc[0], 32'd3);
            check("A_back_to_back", commit_cyc[5] - commit_cyc[0], 32'd5);
        end

        // fetch bubbles hold the pc
        do_reset();
        prog[32'h1000] = movi(5'd1, 20'd1);
        prog[32'h1004] = movi(5'd2, 20'd2);
        expect_commit(5'd1, 32'd1);
        expect_commit(5'd2, 32'd2);
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            check("B_addr_hold", imem_addr, 32'h1004);
            step(1'b0);
        end
        check("B_addr_after_hold", imem_addr, 32'h1004);
        repeat (6) step(1'b1);
        check("B_commit_count", commit_cyc.size(), 32'd2);
        if (commit_cyc.size() == 2)
            check("B_bubble_gap", commit_cyc[1] - commit_cyc[0], 32'd4);

        // taken BEQ squashes the two younger instructions
        do_reset();
        prog[32'h1000] = movi(5'd1, 20'd1);
        prog[32'h1008] = beq(5'd0, 5'd0, 15'h0020);
        prog[32'h100C] = movi(5'd4, 20'd44);
        prog[32'h1010] = movi(5'd5, 20'd55);
        prog[32'h1028] = movi(5'd6, 20'd66);
        expect_commit(5'd1, 32'd1);
        expect_commit(5'd6, 32'd66);
        wait_sig(1'b0, "C_redirect_seen");
        check("C_redirect_cycle", cyc, 32'd4);
        step(1'b1);
        check("C_target", imem_addr, 32'h1028);
        check("C_redirect_pulse", {31'd0, redirect}, 32'd0);
        repeat (6) step(1'b1);

        // JUMP with negative offset; the word fetched in the redirect cycle is dropped
        do_reset();
        prog[32'h1000] = movi(5'd1, 20'h03000);
        prog[32'h1004] = jmp(5'd1, 15'h7FFC);
        prog[32'h1008] = movi(5'd8, 20'd88);
        prog[32'h2FFC] = movi(5'd7, 20'd77);
        expect_commit(5'd1, 32'h3000);
        expect_commit(5'd7, 32'd77);
        wait_sig(1'b0, "D_redirect_seen");
        check("D_redirect_cycle", cyc, 32'd3);
        step(1'b1);
        check("D_target", imem_addr, 32'h2FFC);
        repeat (6) step(1'b1);

        // illegal opcode vectors to PC_EXCEPT; writes to r0 are dropped
        do_reset();
        prog[32'h1000] = movi(5'd1, 20'd3);
        prog[32'h1010] = rr(7'h10, 5'd2, 5'd1, 5'd1);
        prog[32'h1014] = movi(5'd9, 20'd9);
        prog[32'h2000] = movi(5'd0, 20'd9);
        prog[32'h2004] = rr(7'h00, 5'd4, 5'd0, 5'd0);
        prog[32'h2008] = rr(7'h14, 5'd5, 5'd0, 5'd0);
        prog[32'h200C] = movi(5'd10, 20'd10);
        expect_commit(5'd1, 32'd3);
        expect_commit(5'd4, 32'd0);
        expect_commit(5'd5, 32'd0);
        expect_commit(5'd10, 32'd10);
        wait_sig(1'b1, "E_exc_seen");
        check("E_exc_cycle", cyc, 32'd6);
        step(1'b1);
        check("E_vector", imem_addr, 32'h2000);
        check("E_exc_pulse", {31'd0, exc}, 32'd0);
        repeat (8) step(1'b1);

        // reset mid-stream with a MUL in X
        do_reset();
        prog[32'h1000] = movi(5'd1, 20'd6);
        prog[32'h1004] = movi(5'd2, 20'd7);
        prog[32'h1008] = rr(7'h02, 5'd3, 5'd1, 5'd2);
        expect_commit(5'd1, 32'd6);
        expect_commit(5'd2, 32'd7);
        repeat (4) step(1'b1);
        rst = 1'b1;
        step(1'b1);
        check("F_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("F_rst_addr", imem_addr, 32'h1000);
        rst = 1'b0;
        prog.delete();
        prog[32'h1000] = rr(7'h14, 5'd4, 5'd1, 5'd0);
        prog[32'h1004] = rr(7'h00, 5'd5, 5'd2, 5'd3);
        expect_commit(5'd4, 32'd0);
        expect_commit(5'd5, 32'd0);
        repeat (6) step(1'b1);
        check("final_drain", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
